// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve / stall controller.
// Holds the FSM encoding and the predictor handshake widths.
package bp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CMP,
    STALL
  } state_t;

  localparam int DEF_STALL_PENALTY = 5;
  localparam int DEF_CNT_W = 32;
  localparam int PCNT_W = 8;
  localparam int PRED_W = 1;

endpackage

// File: rtl/branch_resolve_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the CPI performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve_stall_ctrl.sv
// Requester-side branch predictor controller: request, compare, train,
// and stall the pipeline on a mispredict.
module branch_resolve_stall_ctrl
  import bp_pkg::*;
#(
  parameter int STALL_PENALTY = DEF_STALL_PENALTY,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic             br_actual_taken,
  output logic             br_ready,
  output logic             predict_request,
  input  logic             predicted_taken,
  output logic             update_enable,
  output logic             actual_taken,
  output logic             stall,
  output logic             mispredict,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic [CNT_W-1:0] stall_count
);

  state_t state, nxt;
  logic lat;
  logic miss;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat   <= 1'b0;
      pcnt  <= '0;
    end else begin
      state <= nxt;
      pcnt  <= pcnt_nxt;
      if ((state == IDLE) && br_valid) begin
        lat <= br_actual_taken;
      end
    end
  end

  always_comb begin
    nxt      = state;
    pcnt_nxt = pcnt;
    // an unknown prediction never matches, so it counts as a miss
    miss     = 1'b1;
    if (predicted_taken == lat) begin
      miss = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (br_valid) nxt = REQ;
      end
      REQ: nxt = CMP;
      CMP: begin
        if (miss && (STALL_PENALTY != 0)) begin
          nxt      = STALL;
          pcnt_nxt = PCNT_W'(STALL_PENALTY);
        end else begin
          nxt = IDLE;
        end
      end
      STALL: begin
        pcnt_nxt = pcnt - 1'b1;
        if (pcnt <= 1) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign br_ready        = (state == IDLE);
  assign predict_request = (state == REQ);
  assign update_enable   = (state == CMP);
  assign actual_taken    = (state == CMP) & lat;
  assign stall           = (state == STALL);
  assign mispredict      = (state == CMP) & miss;

  sat_counter #(.W(CNT_W)) u_instr (
    .clk (clk),
    .rst (rst),
    .inc (update_enable),
    .q   (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_miss (
    .clk (clk),
    .rst (rst),
    .inc (mispredict),
    .q   (mispredict_count)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .q   (stall_count)
  );

endmodule

// File: doc/branch_resolve_stall_ctrl.md
Name: branch_resolve_stall_ctrl

Overview:
Requester-side controller for the global branch predictor interface. It takes resolved branch outcomes from the execute stage and pulses predict_request. One cycle later it samples predicted_taken, compares it with the outcome, and pulses update_enable with actual_taken. On a mispredict it asserts a pipeline stall for STALL_PENALTY cycles. It sits between the execute-stage branch unit and global_branch_predictor, and keeps instruction, mispredict and stall-cycle counters for CPI measurement.

Parameters:
STALL_PENALTY, 5, stall cycles inserted per mispredict; legal range 0..255.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
br_valid  input  1  branch outcome available from execute stage.
br_actual_taken  input  1  resolved direction; qualified by br_valid.
br_ready  output  1  controller can accept a branch this cycle.
predict_request  output  1  one-cycle prediction request to predictor.
predicted_taken  input  1  predictor response; valid the cycle after predict_request.
update_enable  output  1  one-cycle training pulse to predictor.
actual_taken  output  1  outcome sent with update_enable.
stall  output  1  pipeline stall; high during the penalty window.
mispredict  output  1  one-cycle pulse on a detected mispredict.
instr_count  output  CNT_W  branches resolved.
mispredict_count  output  CNT_W  mispredicts detected.
stall_count  output  CNT_W  cycles in which stall was high.

Behaviour:
- Reset: all outputs 0, except br_ready = 1. FSM goes to IDLE, all counters clear, latched outcome = 0.
- Reset has priority over every other event, including mid-stall and mid-request. The next cycle is IDLE with stall = 0.
- FSM states: IDLE, REQ, CMP, STALL.
- IDLE:
  - br_ready = 1.
  - On br_valid && br_ready, latch br_actual_taken and go to REQ. Otherwise stay in IDLE.
  - br_valid is ignored in every non-IDLE state (br_ready = 0). The source must hold br_valid until accepted.
- REQ:
  - predict_request = 1 for exactly this cycle.
  - Go to CMP.
- CMP:
  - Sample predicted_taken.
  - update_enable = 1 and actual_taken = latched outcome, both for exactly this cycle.
  - instr_count += 1.
  - If predicted_taken != latched outcome: mispredict = 1, mispredict_count += 1, load penalty counter with STALL_PENALTY, go to STALL.
  - Exception: when STALL_PENALTY == 0, a mispredict returns to IDLE with no stall.
  - On a correct prediction, go to IDLE.
- STALL:
  - stall = 1, stall_count += 1, penalty counter -= 1.
  - When the counter reaches 1 this cycle, the next state is IDLE.
  - Result: stall is high for exactly STALL_PENALTY consecutive cycles.
- Throughput:
  - Correct prediction: 3 cycles per branch (IDLE accept, REQ, CMP), assuming br_valid is held high.
  - Mispredict: 3 + STALL_PENALTY cycles per branch.
- Outputs are registered or decoded from state only. No combinational path from predicted_taken to any output except mispredict in CMP.
- Counters saturate at all-ones and never wrap. Each counter saturates independently.
- predicted_taken X/Z in CMP counts as a mispredict: mismatch is evaluated as != 1'b0/1'b1 equality, and any non-equal result is a mispredict.
- Penalty counter width is 8 bits; STALL_PENALTY > 255 is illegal.

Decomposition:
- Shared package bp_pkg holds:
  - the state enum (IDLE/REQ/CMP/STALL);
  - the default STALL_PENALTY and CNT_W constants;
  - the predictor handshake signal widths.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst, inc; output q; saturating). It is instantiated three times for the performance counters.

Test Plan:
- Stub predictor always returns taken; 8 taken outcomes back-to-back with br_valid held → each branch takes 3 cycles; instr_count = 8, mispredict_count = 0, stall_count = 0; stall never high.
- Stub returns taken, one not-taken outcome, STALL_PENALTY = 5 → mispredict pulses once; stall high for exactly 5 consecutive cycles starting the cycle after CMP; stall_count = 5; br_ready low throughout.
- 50-branch TTTN pattern, stub always taken → instr_count = 50, mispredict_count = 12, stall_count = 60; predict_request and update_enable pulses each total 50.
- STALL_PENALTY = 0, mispredict → mispredict = 1, stall never asserted, back in IDLE the cycle after CMP, stall_count = 0.
- CNT_W = 4, 20 mispredicts with penalty 1 → instr_count = 15, mispredict_count = 15, stall_count = 15, all held at 15 with no wrap.
- Assert rst on the 3rd stall cycle → next cycle stall = 0, br_ready = 1, all counters 0; a following branch completes normally.
